// File: rtl/counter_mux7seg_pkg.sv
// Shared types and the 7-segment decoder for the multiplexed N-digit counter.
// Pure definitions: no timing or flow control of its own.
// Included by every counter_mux7seg file.
package counter_mux7seg_pkg;

    typedef enum logic [1:0] {
        OP_HOLD = 2'b00,
        OP_LOAD = 2'b01,
        OP_UP   = 2'b10,
        OP_DOWN = 2'b11
    } op_e;

    localparam logic [7:0] SEG_BLANK = 8'hFF;
    localparam logic [7:0] SEG_ZERO  = 8'hC0;

    // Active-high {g,f,e,d,c,b,a}; callers invert for the common-anode pins.
    function automatic logic [6:0] seg_decode(input logic [3:0] i_dig);
        logic [6:0] w_seg;
        case (i_dig)
            4'h0:    w_seg = 7'h3F;
            4'h1:    w_seg = 7'h06;
            4'h2:    w_seg = 7'h5B;
            4'h3:    w_seg = 7'h4F;
            4'h4:    w_seg = 7'h66;
            4'h5:    w_seg = 7'h6D;
            4'h6:    w_seg = 7'h7D;
            4'h7:    w_seg = 7'h07;
            4'h8:    w_seg = 7'h7F;
            4'h9:    w_seg = 7'h6F;
            4'hA:    w_seg = 7'h77;
            4'hB:    w_seg = 7'h7C;
            4'hC:    w_seg = 7'h39;
            4'hD:    w_seg = 7'h5E;
            4'hE:    w_seg = 7'h79;
            default: w_seg = 7'h71;
        endcase
        return w_seg;
    endfunction

endpackage

// File: rtl/mux7seg_scan.sv
// Digit scanner: rotates the active anode and drives the decoded segments (LEADING_ZERO_BLANK_EN blanks leading zeros).
// Latency: AN/SEG are registered, one cycle behind the digit index and the count.
// Backpressure: none, free-running display path.
module mux7seg_scan
    import counter_mux7seg_pkg::*;
#(
    parameter int NDIGITS  = 4,
    parameter int SCAN_PER = 50000
) (
    input  logic                   i_clk,
    input  logic                   i_rst_n,
    input  logic [4*NDIGITS-1:0]   i_q,
    output logic [NDIGITS-1:0]     o_an,
    output logic [7:0]             o_seg
);

    localparam int                 SW        = $clog2(SCAN_PER);
    localparam logic [SW-1:0]      SCAN_LAST = SW'(SCAN_PER - 1);
    localparam int                 IW        = (NDIGITS > 1) ? $clog2(NDIGITS) : 1;
    localparam logic [IW-1:0]      IDX_LAST  = IW'(NDIGITS - 1);
    localparam logic [NDIGITS-1:0] AN_ONE    = NDIGITS'(1);

    logic [SW-1:0]      r_scan_cnt;
    logic [IW-1:0]      r_idx;
    logic [NDIGITS-1:0] r_an;
    logic [7:0]         r_seg;
    logic               w_scan;
    logic [3:0]         w_dig;
    logic               w_lead_zero;
    logic               w_higher_zero;
    logic               w_blank_en;

`ifdef LEADING_ZERO_BLANK_EN
    assign w_blank_en = 1'b1;
`else
    assign w_blank_en = 1'b0;
`endif

    assign w_scan = (r_scan_cnt == SCAN_LAST);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_scan_cnt <= '0;
            r_idx      <= '0;
        end else begin
            if (w_scan) begin
                r_scan_cnt <= '0;
                r_idx      <= (r_idx == IDX_LAST) ? '0 : r_idx + 1'b1;
            end else begin
                r_scan_cnt <= r_scan_cnt + 1'b1;
            end
        end
    end

    // Walk from the top digit down so each digit knows whether everything above it is zero.
    always_comb begin
        w_dig         = 4'd0;
        w_lead_zero   = 1'b0;
        w_higher_zero = 1'b1;
        for (int i = NDIGITS - 1; i >= 0; i--) begin
            if (r_idx == IW'(i)) begin
                w_dig       = i_q[4*i +: 4];
                w_lead_zero = w_higher_zero && (i_q[4*i +: 4] == 4'd0) && (i != 0);
            end
            w_higher_zero = w_higher_zero && (i_q[4*i +: 4] == 4'd0);
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_an  <= ~AN_ONE;
            r_seg <= SEG_ZERO;
        end else begin
            r_an  <= ~(AN_ONE << r_idx);
            r_seg <= (w_blank_en && w_lead_zero) ? SEG_BLANK : {1'b1, ~seg_decode(w_dig)};
        end
    end

    assign o_an  = r_an;
    assign o_seg = r_seg;

endmodule

// File: rtl/counter_mux7seg_n.sv
// N-digit hex/BCD up/down/load counter with a time-multiplexed common-anode 7-segment display.
// Latency: Q/TC update on the tick edge; AN/SEG follow one cycle later.
// Backpressure: none; inputs are sampled only on tick edges.
module counter_mux7seg_n
    import counter_mux7seg_pkg::*;
#(
    parameter int FPGAFREQ  = 50_000_000,
    parameter int COUNTFREQ = 1,
    parameter int SCANFREQ  = 1000,
    parameter int NDIGITS   = 4,
    parameter int DECIMAL   = 0
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic                 EN,
    input  logic [1:0]           S,
    input  logic [4*NDIGITS-1:0] D,
    output logic [4*NDIGITS-1:0] Q,
    output logic                 TC,
    output logic [NDIGITS-1:0]   AN,
    output logic [7:0]           SEG
);

    localparam int            TICK_PER  = FPGAFREQ / COUNTFREQ;
    localparam int            TW        = $clog2(TICK_PER);
    localparam logic [TW-1:0] TICK_LAST = TW'(TICK_PER - 1);
    localparam logic [3:0]    DIG_MAX   = (DECIMAL != 0) ? 4'd9 : 4'hF;

    logic [TW-1:0]        r_tick_cnt;
    logic [4*NDIGITS-1:0] r_q;
    logic                 r_tc;
    logic                 w_tick;
    op_e                  w_op;
    logic [4*NDIGITS-1:0] w_q_up;
    logic [4*NDIGITS-1:0] w_q_dn;
    logic [4*NDIGITS-1:0] w_q_ld;
    logic                 w_carry;
    logic                 w_borrow;

    assign w_tick = (r_tick_cnt == TICK_LAST);
    assign w_op   = op_e'(S);

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_tick_cnt <= '0;
        end else if (w_tick) begin
            r_tick_cnt <= '0;
        end else begin
            r_tick_cnt <= r_tick_cnt + 1'b1;
        end
    end

    // Ripple carry/borrow; a carry or borrow surviving the top digit is the wrap.
    always_comb begin
        w_q_up   = r_q;
        w_q_dn   = r_q;
        w_q_ld   = D;
        w_carry  = 1'b1;
        w_borrow = 1'b1;
        for (int i = 0; i < NDIGITS; i++) begin
            if (w_carry) begin
                if (r_q[4*i +: 4] >= DIG_MAX) begin
                    w_q_up[4*i +: 4] = 4'd0;
                end else begin
                    w_q_up[4*i +: 4] = r_q[4*i +: 4] + 4'd1;
                    w_carry          = 1'b0;
                end
            end
            if (w_borrow) begin
                if (r_q[4*i +: 4] == 4'd0) begin
                    w_q_dn[4*i +: 4] = DIG_MAX;
                end else begin
                    w_q_dn[4*i +: 4] = r_q[4*i +: 4] - 4'd1;
                    w_borrow         = 1'b0;
                end
            end
            if ((DECIMAL != 0) && (D[4*i +: 4] > 4'd9)) begin
                w_q_ld[4*i +: 4] = 4'd9;
            end
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_q  <= '0;
            r_tc <= 1'b0;
        end else begin
            r_tc <= 1'b0;
            if (w_tick && EN) begin
                case (w_op)
                    OP_LOAD: r_q <= w_q_ld;
                    OP_UP: begin
                        r_q  <= w_q_up;
                        r_tc <= w_carry;
                    end
                    OP_DOWN: begin
                        r_q  <= w_q_dn;
                        r_tc <= w_borrow;
                    end
                    default: r_q <= r_q;
                endcase
            end
        end
    end

    mux7seg_scan #(
        .NDIGITS  (NDIGITS),
        .SCAN_PER (FPGAFREQ / SCANFREQ)
    ) u_scan (
        .i_clk   (CLK),
        .i_rst_n (RST),
        .i_q     (r_q),
        .o_an    (AN),
        .o_seg   (SEG)
    );

    assign Q  = r_q;
    assign TC = r_tc;

endmodule

// File: tb/tb_counter_mux7seg_n.sv
// Bench for counter_mux7seg_n: hex and BCD instances side by side, checked every cycle against an arithmetic model.
module tb_counter_mux7seg_n;

    logic       CLK;
    logic       RST;
    logic       EN;
    logic [1:0] S;
    logic [7:0] D;
    logic [7:0] q_h, q_b, seg_h, seg_b;
    logic [1:0] an_h, an_b;
    logic       tc_h, tc_b;

    int         total;
    int         bad;
    int         k;
    int         mh;
    int         md;
    logic [7:0] prev_h, prev_b;
    logic       exp_tc_h, exp_tc_b;
    logic [6:0] seg_tab [16];

    typedef struct {
        logic [1:0] s;
        logic       en;
        logic [7:0] d;
        logic [7:0] exp_h;
        logic [7:0] exp_b;
    } vec_t;
    vec_t vecs [12];

    counter_mux7seg_n #(
        .FPGAFREQ(8), .COUNTFREQ(2), .SCANFREQ(4), .NDIGITS(2), .DECIMAL(0)
    ) u_hex (
        .CLK(CLK), .RST(RST), .EN(EN), .S(S), .D(D),
        .Q(q_h), .TC(tc_h), .AN(an_h), .SEG(seg_h)
    );

    counter_mux7seg_n #(
        .FPGAFREQ(8), .COUNTFREQ(2), .SCANFREQ(4), .NDIGITS(2), .DECIMAL(1)
    ) u_bcd (
        .CLK(CLK), .RST(RST), .EN(EN), .S(S), .D(D),
        .Q(q_b), .TC(tc_b), .AN(an_b), .SEG(seg_b)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s at t=%0t: got %0h want %0h", nm, $time, act, exp);
        end
    endtask

    function automatic logic [7:0] to_bcd(input int v);
        return {4'(v / 10), 4'(v % 10)};
    endfunction

    function automatic logic [1:0] exp_an(input int idx);
        return (idx == 0) ? 2'b10 : 2'b01;
    endfunction

    function automatic logic [7:0] exp_seg(input logic [7:0] q, input int idx);
        logic [3:0] dig;
        dig = (idx == 0) ? q[3:0] : q[7:4];
`ifdef LEADING_ZERO_BLANK_EN
        if (idx == 1 && q[7:4] == 4'd0) return 8'hFF;
`endif
        return {1'b1, ~seg_tab[dig]};
    endfunction

    task automatic reset_model();
        k        = 0;
        mh       = 0;
        md       = 0;
        prev_h   = 8'h00;
        prev_b   = 8'h00;
        exp_tc_h = 1'b0;
        exp_tc_b = 1'b0;
    endtask

    task automatic check_outputs();
        int idx;
        idx = (k == 0) ? 0 : ((k - 1) / 2) % 2;
        chk("q_hex",   32'(q_h),   32'(mh[7:0]));
        chk("q_bcd",   32'(q_b),   32'(to_bcd(md)));
        chk("tc_hex",  32'(tc_h),  32'(exp_tc_h));
        chk("tc_bcd",  32'(tc_b),  32'(exp_tc_b));
        chk("an_hex",  32'(an_h),  32'(exp_an(idx)));
        chk("an_bcd",  32'(an_b),  32'(exp_an(idx)));
        chk("seg_hex", 32'(seg_h), 32'(exp_seg(prev_h, idx)));
        chk("seg_bcd", 32'(seg_b), 32'(exp_seg(prev_b, idx)));
    endtask

    // One clock: the op is only presented on the tick edge, junk elsewhere.
    task automatic do_cycle(input logic [1:0] s_t, input logic en_t, input logic [7:0] d_t);
        bit tick;
        int t, o;
        tick = ((k + 1) % 4) == 0;
        if (tick) begin
            S = s_t; EN = en_t; D = d_t;
        end else begin
            S  = 2'($urandom_range(0, 3));
            EN = ($urandom_range(0, 1) != 0);
            D  = 8'($urandom_range(0, 255));
        end
        @(posedge CLK);
        prev_h   = mh[7:0];
        prev_b   = to_bcd(md);
        exp_tc_h = 1'b0;
        exp_tc_b = 1'b0;
        if (tick && en_t) begin
            case (s_t)
                2'b01: begin
                    mh = int'(d_t);
                    t  = (d_t[7:4] > 4'd9) ? 9 : int'(d_t[7:4]);
                    o  = (d_t[3:0] > 4'd9) ? 9 : int'(d_t[3:0]);
                    md = t * 10 + o;
                end
                2'b10: begin
                    exp_tc_h = (mh == 255);
                    exp_tc_b = (md == 99);
                    mh = (mh + 1) % 256;
                    md = (md + 1) % 100;
                end
                2'b11: begin
                    exp_tc_h = (mh == 0);
                    exp_tc_b = (md == 0);
                    mh = (mh + 255) % 256;
                    md = (md + 99) % 100;
                end
                default: ;
            endcase
        end
        k++;
        @(negedge CLK);
        check_outputs();
    endtask

    task automatic do_tick(input logic [1:0] s_t, input logic en_t, input logic [7:0] d_t);
        repeat (4) do_cycle(s_t, en_t, d_t);
    endtask

    initial begin
        total = 0;
        bad   = 0;
        seg_tab = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
        vecs[0]  = '{2'b10, 1'b1, 8'h00, 8'h01, 8'h01};
        vecs[1]  = '{2'b11, 1'b1, 8'h00, 8'h00, 8'h00};
        vecs[2]  = '{2'b11, 1'b1, 8'h00, 8'hFF, 8'h99};
        vecs[3]  = '{2'b11, 1'b1, 8'h00, 8'hFE, 8'h98};
        vecs[4]  = '{2'b01, 1'b1, 8'h3C, 8'h3C, 8'h39};
        vecs[5]  = '{2'b01, 1'b0, 8'h77, 8'h3C, 8'h39};
        vecs[6]  = '{2'b00, 1'b1, 8'h12, 8'h3C, 8'h39};
        vecs[7]  = '{2'b01, 1'b1, 8'h09, 8'h09, 8'h09};
        vecs[8]  = '{2'b10, 1'b1, 8'h00, 8'h0A, 8'h10};
        vecs[9]  = '{2'b01, 1'b1, 8'hFF, 8'hFF, 8'h99};
        vecs[10] = '{2'b10, 1'b1, 8'h00, 8'h00, 8'h00};
        vecs[11] = '{2'b10, 1'b0, 8'h00, 8'h00, 8'h00};

        RST = 1'b0; EN = 1'b0; S = 2'b00; D = 8'h00;
        repeat (2) @(negedge CLK);
        reset_model();
        check_outputs();
        RST = 1'b1;

        foreach (vecs[i]) begin
            do_tick(vecs[i].s, vecs[i].en, vecs[i].d);
            chk("vec_q_hex", 32'(q_h), 32'(vecs[i].exp_h));
            chk("vec_q_bcd", 32'(q_b), 32'(vecs[i].exp_b));
        end

        // Full hex sweep ending in the FF->00 wrap.
        do_tick(2'b01, 1'b1, 8'h00);
        for (int i = 0; i < 256; i++) begin
            do_tick(2'b10, 1'b1, 8'h00);
            if (i == 255) begin
                chk("wrap_tc_hex", 32'(tc_h), 32'd1);
                chk("wrap_q_hex",  32'(q_h),  32'd0);
            end
        end
        do_cycle(2'b00, 1'b1, 8'h00);
        chk("wrap_tc_clear", 32'(tc_h), 32'd0);
        repeat (3) do_cycle(2'b00, 1'b1, 8'h00);

        for (int i = 0; i < 150; i++) begin
            do_tick(2'($urandom_range(0, 3)), ($urandom_range(0, 3) != 0),
                    8'($urandom_range(0, 255)));
        end

        do_tick(2'b01, 1'b1, 8'h5A);
        do_cycle(2'b00, 1'b1, 8'h00);
        repeat (4) begin
            do_cycle(2'b00, 1'b1, 8'h00);
            chk("scan_seg_5a", 32'(seg_h), (an_h == 2'b10) ? 32'h88 : 32'h92);
        end
        repeat (3) do_cycle(2'b00, 1'b1, 8'h00);

        do_tick(2'b01, 1'b1, 8'h07);
        do_cycle(2'b00, 1'b1, 8'h00);
        repeat (4) begin
            do_cycle(2'b00, 1'b1, 8'h00);
`ifdef LEADING_ZERO_BLANK_EN
            chk("scan_seg_07", 32'(seg_h), (an_h == 2'b10) ? 32'hF8 : 32'hFF);
`else
            chk("scan_seg_07", 32'(seg_h), (an_h == 2'b10) ? 32'hF8 : 32'hC0);
`endif
        end
        repeat (3) do_cycle(2'b00, 1'b1, 8'h00);

        // Asynchronous reset in the middle of a tick period.
        do_tick(2'b01, 1'b1, 8'h23);
        repeat (2) do_cycle(2'b00, 1'b1, 8'h00);
        chk("pre_rst_q", 32'(q_h), 32'h23);
        #2 RST = 1'b0;
        #1;
        chk("rst_q_hex",   32'(q_h),   32'h00);
        chk("rst_q_bcd",   32'(q_b),   32'h00);
        chk("rst_an",      32'(an_h),  32'h2);
        chk("rst_seg",     32'(seg_h), 32'hC0);
        chk("rst_tc",      32'(tc_h),  32'd0);
        @(negedge CLK);
        reset_model();
        check_outputs();
        RST = 1'b1;
        repeat (3) do_cycle(2'b10, 1'b1, 8'h00);
        chk("post_rst_hold", 32'(q_h), 32'h00);
        do_cycle(2'b10, 1'b1, 8'h00);
        chk("post_rst_inc_hex", 32'(q_h), 32'h01);
        chk("post_rst_inc_bcd", 32'(q_b), 32'h01);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
